rect_draw_engine: RTL

- Parametrised rectangle rasteriser for the VGA adapter path (default 160x120, 3-bit colour).
- Successor to the fixed 8x8 square datapath: rectangle width and height are runtime inputs.
- Adds a start/busy/done handshake, screen-edge clipping and a registered colour.
- Emits one pixel per clock (x, y, colour, plot) straight into the adapter's write port.

---
 rtl/rect_draw_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: one pixel per clock into the VGA adapter write port.
// Define RECT_OUTLINE_EN to add the outline-only drawing mode.
`timescale 1ns/1ps
module rect_draw_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SIZE_W   = 6,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [SIZE_W-1:0]   w_in,
    input  logic [SIZE_W-1:0]   h_in,
    input  logic [COLOUR_W-1:0] colour_in,
`ifdef RECT_OUTLINE_EN
    input  logic                outline,
`endif
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    logic [1:0]          state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [SIZE_W-1:0]   w_q, w_d;
    logic [SIZE_W-1:0]   h_q, h_d;
    logic [SIZE_W-1:0]   cx_q, cx_d;
    logic [SIZE_W-1:0]   cy_q, cy_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic                ol_q, ol_d;

    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic [SIZE_W-1:0]   w_last;
    logic [SIZE_W-1:0]   h_last;
    logic                last_x;
    logic                last_y;
    logic                skip;
    logic                drawing;

    assign w_last  = w_q - 1'b1;
    assign h_last  = h_q - 1'b1;
    assign last_x  = (cx_q == w_last);
    assign last_y  = (cy_q == h_last);
    assign drawing = (state_q == DRAW);

    // Interior outline rows jump from the left edge straight to the right edge.
    assign skip = ol_q && (cx_q == '0) && (cy_q != '0) && !last_y;

    assign sum_x = (X_W+1)'(x0_q) + (X_W+1)'(cx_q);
    assign sum_y = (Y_W+1)'(y0_q) + (Y_W+1)'(cy_q);

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign colour_out = col_q;
    assign x_out      = drawing ? sum_x[X_W-1:0] : '0;
    assign y_out      = drawing ? sum_y[Y_W-1:0] : '0;
    assign plot       = drawing && (sum_x < SCR_W) && (sum_y < SCR_H);

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        ol_d    = ol_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d  = x_in;
                    y0_d  = y_in;
                    w_d   = w_in;
                    h_d   = h_in;
                    col_d = colour_in;
`ifdef RECT_OUTLINE_EN
                    ol_d  = outline;
`else
                    ol_d  = 1'b0;
`endif
                    cx_d  = '0;
                    cy_d  = '0;
                    if (w_in == '0 || h_in == '0)
                        state_d = DONE;
                    else
                        state_d = DRAW;
                end
            end
            DRAW: begin
                if (last_x) begin
                    cx_d = '0;
                    if (last_y)
                        state_d = DONE;
                    else
                        cy_d = cy_q + 1'b1;
                end else if (skip) begin
                    cx_d = w_last;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            ol_q    <= ol_d;
        end
    end

endmodule
